// File: rtl/proc_defs.sv
// ---------------------------------------------------------------------------
// proc_defs
//   Instruction-word definitions shared by the fetch stage and the core's
//   decode stage: word width, opcode field position and the NOP encoding.
// ---------------------------------------------------------------------------
package proc_defs;

    localparam int INS_W  = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;

    localparam logic [INS_W-1:0] NOP_WORD = '0;

    // Extract the opcode field from an instruction word.
    function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INS_W-1:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO buffering fetched {instruction, pc} pairs.
//   The head entry is presented from the storage array (no bypass), so a push
//   into an empty FIFO becomes visible on the following cycle.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   retire the head entry this cycle
//   flush  in   discard all entries (takes priority over push/pop)
//   din    in   W-bit entry to write
//   dout   out  W-bit head entry
//   empty  out  no entries held
//   full   out  DEPTH entries held
//   count  out  number of entries held
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & !full;
    assign w_do_pop  = pop & !empty;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once the
    // pointers/count say they were written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: owns the PC, reads a synchronous (1-cycle) instruction
//   memory, buffers returned words in fetch_fifo and presents them to the core
//   with a valid/ready handshake. A jump redirect flushes buffered and
//   in-flight words and restarts fetching at the target.
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   imem_en     out  instruction memory read strobe
//   imem_addr   out  read address (current PC)
//   imem_rdata  in   read data, valid the cycle after imem_en
//   ins_do      out  instruction word to the core (NOP when not valid)
//   ins_pc      out  address of ins_do (0 when not valid)
//   ins_valid   out  ins_do/ins_pc valid
//   ins_ready   in   core accepts the word
//   jmp_en      in   redirect pulse
//   jmp_addr    in   redirect target
// ---------------------------------------------------------------------------
module instruction_fetch
    import proc_defs::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins_do,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;
    localparam int FW    = INS_W + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic [CRD_W-1:0]  w_credit_use;
    logic [FW-1:0]     w_din;
    logic [FW-1:0]     w_dout;

    assign w_pop  = !w_empty & ins_ready;
    // A redirect in the return cycle squashes the word coming back.
    assign w_push = r_inflight & !jmp_en;

    // Slots committed after this edge: buffered + returning - leaving. Issuing
    // only while this is below DEPTH guarantees room for every returning word.
    assign w_credit_use = CRD_W'(w_count) + CRD_W'(r_inflight) - CRD_W'(w_pop);
    assign w_issue      = !rst & !jmp_en & (w_credit_use < CRD_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (jmp_en)       r_pc <= jmp_addr;
            else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
        end
    end

    assign w_din = {imem_rdata, r_inflight_pc};

    fetch_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (jmp_en),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) (w_push |-> !w_full));

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign ins_valid = !w_empty;
    assign ins_do    = w_empty ? NOP_WORD : w_dout[FW-1:ADDR_W];
    assign ins_pc    = w_empty ? '0 : w_dout[ADDR_W-1:0];

endmodule
